// File: rtl/dmem_bank.sv
// dmem_bank: parametrised single-port data memory with per-byte write
// enables, a valid/ready request port and a registered response port.
//
// Optional feature macro: DMEM_INIT_CLEAR_EN
//   defined   : after reset an INIT sequence clears one word per cycle
//               (DEPTH cycles) before requests are accepted.
//   undefined : no clear sequence; init_done rises on the first clock edge
//               after reset release and memory contents start undefined.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    request present
//   req_ready    request accepted when high together with req_valid
//   req_we       1 = write, 0 = read
//   req_addr     byte address
//   req_wdata    write data
//   req_be       byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid    response valid, held until rsp_ready
//   rsp_ready    consumer accepts response
//   rsp_rdata    read data (0 for writes and errors)
//   rsp_err      request was out of range or misaligned
//   init_done    memory ready for requests
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             run;
  logic             accept;
  logic             err;
  logic [IDX_W-1:0] widx;

  assign widx = req_addr[OFF +: IDX_W];

  // Misalignment uses a mask so that BYTES == 1 (no offset bits) needs no
  // special case; the range check uses the full word index, so any set
  // upper address bit is flagged as out of range.
  assign err = ((req_addr & ALIGN_MASK) != '0) || ((req_addr >> OFF) >= DEPTH_A);

  assign req_ready = run && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign init_done = run;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign run = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (accept && req_we && !err) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (req_be[b]) mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end
`else
  logic run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign run = run_q;

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (req_be[b]) mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end
`endif

  // Read data is taken from the pre-write memory contents at the accepting
  // edge; writes and errored requests respond with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (req_we || err) ? '0 : mem[widx];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_bank.sv
module tb_dmem_bank;

`ifdef DMEM_INIT_CLEAR_EN
  localparam int EXP_INIT = 16;
`else
  localparam int EXP_INIT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_pass;
  int n_total;

  dmem_bank #(.DATA_W(32), .DEPTH(16), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Count rising edges after reset release until init_done; starts at a negedge.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  // One request with rsp_ready = 1; starts and ends at a negedge.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output logic er);
    int w;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid_lat1", {31'b0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] be, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xact(1'b1, addr, wd, be, rd, er);
    check({tag, "_wdata0"}, rd, 32'h0);
    check({tag, "_werr"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic rdc(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                     input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xact(1'b0, addr, 32'h0, 4'h0, rd, er);
    check({tag, "_rdata"}, rd, exp);
    check({tag, "_rerr"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    int n;
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);

    // Clear sequence length
    rst_n = 1'b1;
    wait_init(n);
    check("init_cycles", n, EXP_INIT);
    check("ready_after_init", {31'b0, req_ready}, 32'd1);

`ifdef DMEM_INIT_CLEAR_EN
    for (int i = 0; i < 16; i++) rdc("clr_word", 32'(i * 4), 32'h0, 1'b0);
`endif

    // Byte-enable merge and no-op write
    wr("w_full", 32'h08, 32'hDEADBEEF, 4'hF, 1'b0);
    wr("w_low2", 32'h08, 32'h00001234, 4'b0011, 1'b0);
    rdc("r_merge", 32'h08, 32'hDEAD1234, 1'b0);
    wr("w_be0", 32'h08, 32'hFFFFFFFF, 4'h0, 1'b0);
    rdc("r_after_be0", 32'h08, 32'hDEAD1234, 1'b0);
    wr("w_0c", 32'h0C, 32'h11111111, 4'hF, 1'b0);
    wr("w_10", 32'h10, 32'h22222222, 4'hF, 1'b0);
    wr("w_00", 32'h00, 32'h5A5A5A5A, 4'hF, 1'b0);

    // Back-to-back reads, one response per cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08;
    @(negedge clk);
    check("b2b_v0", {31'b0, rsp_valid}, 32'd1);
    check("b2b_d0", rsp_rdata, 32'hDEAD1234);
    req_addr = 32'h0C;
    @(negedge clk);
    check("b2b_v1", {31'b0, rsp_valid}, 32'd1);
    check("b2b_d1", rsp_rdata, 32'h11111111);
    req_addr = 32'h10;
    @(negedge clk);
    check("b2b_v2", {31'b0, rsp_valid}, 32'd1);
    check("b2b_d2", rsp_rdata, 32'h22222222);
    // Write then read of the same word in consecutive cycles
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(negedge clk);
    check("raw_wresp", rsp_rdata, 32'h0);
    req_we = 1'b0;
    @(negedge clk);
    check("raw_rdata", rsp_rdata, 32'hCAFEF00D);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_drain", {31'b0, rsp_valid}, 32'd0);

    // Range and alignment errors
    rdc("r_oor", 32'h40, 32'h0, 1'b1);
    rdc("r_mis", 32'h06, 32'h0, 1'b1);
    rdc("r_hi", 32'h80000000, 32'h0, 1'b1);
    wr("w_41", 32'h41, 32'hFFFFFFFF, 4'hF, 1'b1);
    wr("w_09", 32'h09, 32'hFFFFFFFF, 4'hF, 1'b1);
    wr("w_hi", 32'h80000008, 32'hFFFFFFFF, 4'hF, 1'b1);
    rdc("r_w0_kept", 32'h00, 32'h5A5A5A5A, 1'b0);
    rdc("r_w2_kept", 32'h08, 32'hDEAD1234, 1'b0);

    // Response backpressure
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h18; req_wdata = 32'h77777777; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'hDEAD1234);
      check("stall_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("release_valid", {31'b0, rsp_valid}, 32'd1);
    check("release_wresp", rsp_rdata, 32'h0);
    @(negedge clk);
    check("release_drain", {31'b0, rsp_valid}, 32'd0);
    rdc("r_18", 32'h18, 32'h77777777, 1'b0);

    // Reset with a response pending
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14;
    @(negedge clk);
    req_valid = 1'b0;
    check("pend_valid", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("pend_drop", {31'b0, rsp_valid}, 32'd0);
    check("pend_init_done", {31'b0, init_done}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    check("reinit_cycles", n, EXP_INIT);

    // Reset asserted partway through the clear sequence
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midinit_done", {31'b0, init_done}, 32'd0);
    rst_n = 1'b1;
    wait_init(n);
    check("midinit_cycles", n, EXP_INIT);
`ifdef DMEM_INIT_CLEAR_EN
    rdc("r_cleared_08", 32'h08, 32'h0, 1'b0);
    rdc("r_cleared_18", 32'h18, 32'h0, 1'b0);
`endif

    // Top word
    wr("w_3c", 32'h3C, 32'hA5C3_0F96, 4'hF, 1'b0);
    rdc("r_3c", 32'h3C, 32'hA5C3_0F96, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
